vco_adc_capture: RTL and testbench
==================================

Name: vco_adc_capture

Overview:
- Sink-side capture buffer for the VCO ADC decimated output stream (32-bit `data_out` with a single-cycle `data_valid_out` strobe, no backpressure).
- On a start command it records a programmed number of samples (or records continuously) into a synchronous FIFO.
- A host-side read port with 1-cycle latency drains the FIFO. Status flags expose occupancy, overflow and completion to the management/register layer.

Parameters:
- DATA_WIDTH, 32, sample width; matches the ADC output word.
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries (default 16).
- LEN_WIDTH, 10, width of the capture length field.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- sample_in  input  DATA_WIDTH  ADC sample word.
- sample_valid_in  input  1  single-cycle strobe; `sample_in` is valid this cycle.
- start_in  input  1  pulse: clear buffer/flags, begin capture.
- stop_in  input  1  pulse: end capture (meaningful in continuous mode).
- capture_len_in  input  LEN_WIDTH  samples to capture; 0 = continuous. Sampled on `start_in`.
- rd_en_in  input  1  read request.
- rd_data_out  output  DATA_WIDTH  read data.
- rd_valid_out  output  1  `rd_data_out` valid this cycle.
- count_out  output  DEPTH_LOG2+1  FIFO occupancy.
- empty_out  output  1  count == 0.
- full_out  output  1  count == 2^DEPTH_LOG2.
- overflow_out  output  1  sticky: at least one sample dropped since last start.
- busy_out  output  1  state == CAPTURE.
- done_out  output  1  state == DONE.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `rst`. All state is updated on posedge `clk`.
- Reset values:
  - state = IDLE.
  - rd_ptr = wr_ptr = 0, count = 0.
  - `rd_data_out` = 0, `rd_valid_out` = 0, `overflow_out` = 0, `busy_out` = 0, `done_out` = 0.
  - `empty_out` = 1, `full_out` = 0.
- Reset mid-capture discards all contents.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE --start_in--> CAPTURE.
  - CAPTURE --(len != 0 and seen_cnt reaches len) or stop_in--> DONE.
  - DONE --start_in--> CAPTURE.
  - `stop_in` in IDLE/DONE is ignored.
- Start, accepted in any state, including CAPTURE (restart):
  - Flush pointers and count to 0.
  - Clear `overflow_out`, `done_out` and seen_cnt.
  - Latch `capture_len_in` into len_reg.
  - A `sample_valid_in` in the same cycle as `start_in` is ignored.
  - A `rd_en_in` in the same cycle as `start_in` is ignored (`rd_valid_out` = 0 next cycle).
- Write path:
  - Only in CAPTURE, and only when `sample_valid_in` = 1.
  - seen_cnt increments for every valid sample, accepted or dropped, so termination is deterministic.
  - seen_cnt saturates; it is not compared when len_reg = 0.
  - The sample that makes seen_cnt == len_reg is written (if space), and the state moves to DONE the same edge.
  - `stop_in` and `sample_valid_in` in the same cycle: the sample is written, then the state moves to DONE.
  - Samples arriving in IDLE/DONE are discarded without setting overflow.
- Full handling:
  - If full with no simultaneous read, the sample is dropped and `overflow_out` is set (sticky).
  - If full with a simultaneous accepted read, the write is accepted and count is unchanged.
- Read path:
  - A read is accepted when `rd_en_in` = 1 and count != 0 (pre-edge value); allowed in any state.
  - Next cycle: `rd_data_out` = mem[rd_ptr_old] and `rd_valid_out` = 1.
  - `rd_en_in` on empty: no pointer change, `rd_valid_out` = 0 next cycle, and `rd_data_out` holds its last value.
  - No fall-through: on empty with a simultaneous write, the write is accepted and the read is ignored.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- count:
  - +1 on write only, −1 on read only, unchanged on both.
  - Never exceeds 2^DEPTH_LOG2 and never goes below 0.
- `empty_out`, `full_out`, `count_out`, `busy_out` and `done_out` are decoded from registered state (no combinational path from inputs).
- Memory is a plain register array with no reset requirement on its contents.

Test Plan:
- Bounded capture: reset; `start_in` with len = 5; drive 5 valid samples 0x100..0x104 spaced 3 cycles apart → `busy_out` = 1 during capture; `done_out` = 1 on the edge after the 5th sample; count = 5; `overflow_out` = 0; later samples are ignored.
- Readback ordering/latency: after the above, hold `rd_en_in` for 6 cycles → `rd_valid_out` pulses 5 times, each one cycle after its request, with data 0x100..0x104 in order; the 6th request gives `rd_valid_out` = 0; `empty_out` = 1 at the end.
- Overflow: DEPTH_LOG2 = 4, len = 0, push 20 samples with no reads → count = 16, `full_out` = 1, `overflow_out` = 1; `stop_in` → DONE; reading yields the first 16 samples only.
- Full with simultaneous read/write: fill to 16, then assert `sample_valid_in` and `rd_en_in` together with data 0xAA → count stays 16, `overflow_out` stays 0; 0xAA is the last word read out.
- Restart and control collisions:
  - `start_in` mid-capture with 7 samples buffered and overflow set → count = 0 and `overflow_out` = 0 next cycle, new len latched.
  - `sample_valid_in` coincident with `start_in` is not stored.
  - `stop_in` coincident with a sample stores that sample.
- Reset mid-operation: assert `rst` with count = 9 in CAPTURE → next cycle count = 0, `empty_out` = 1, state IDLE; `rd_en_in` then gives `rd_valid_out` = 0.

Source files
------------

// File: rtl/vco_adc_capture.sv
// vco_adc_capture
// ---------------
// Sink-side capture buffer for the decimated VCO ADC sample stream.
// A start pulse flushes the buffer and arms a capture of capture_len_in
// samples, or an open-ended capture when the length is zero. Captured
// samples land in a synchronous FIFO that the host drains through a read
// port with one cycle of latency. Status flags report occupancy, sticky
// overflow and capture progress.
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   sample_in        ADC sample word
//   sample_valid_in  single-cycle strobe qualifying sample_in
//   start_in         pulse: flush buffer and flags, begin capture
//   stop_in          pulse: end an ongoing capture
//   capture_len_in   samples to capture (0 = continuous), taken on start_in
//   rd_en_in         host read request
//   rd_data_out      read data, valid the cycle after an accepted request
//   rd_valid_out     rd_data_out carries a freshly read word
//   count_out        FIFO occupancy
//   empty_out        FIFO holds no samples
//   full_out         FIFO holds 2^DEPTH_LOG2 samples
//   overflow_out     at least one sample dropped since the last start
//   busy_out         capture in progress
//   done_out         capture finished
module vco_adc_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    input  logic                  start_in,
    input  logic                  stop_in,
    input  logic [LEN_WIDTH-1:0]  capture_len_in,
    input  logic                  rd_en_in,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_valid_out,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic                  overflow_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t                  state;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic [LEN_WIDTH-1:0]    seen_cnt;
    logic [LEN_WIDTH-1:0]    len_reg;
    logic                    overflow;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    rd_accept;
    logic                    sample_seen;
    logic                    wr_accept;
    logic [LEN_WIDTH-1:0]    seen_next;
    logic                    len_hit;

    // Per-cycle decisions. A start pulse takes precedence over everything
    // else in its cycle, so a coincident sample or read is simply ignored.
    // A write into a full FIFO still goes through when a read frees a slot
    // on the same edge. Reads look only at the pre-edge count, so an empty
    // FIFO never forwards a word being written in the same cycle.
    always_comb begin
        rd_accept   = rd_en_in && (count != '0) && !start_in;
        sample_seen = (state == CAPTURE) && sample_valid_in && !start_in;
        wr_accept   = sample_seen && ((count != FULL_COUNT) || rd_accept);
        seen_next   = (seen_cnt == '1) ? seen_cnt : seen_cnt + LEN_WIDTH'(1);
        len_hit     = sample_seen && (len_reg != '0) && (seen_next == len_reg);
    end

    // Control, pointers, occupancy and the registered read port. The sample
    // counter advances on every valid sample, including dropped ones, so a
    // bounded capture always ends after exactly len samples have arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            seen_cnt     <= '0;
            len_reg      <= '0;
            overflow     <= 1'b0;
            rd_data_out  <= '0;
            rd_valid_out <= 1'b0;
        end else if (start_in) begin
            state        <= CAPTURE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            seen_cnt     <= '0;
            len_reg      <= capture_len_in;
            overflow     <= 1'b0;
            rd_valid_out <= 1'b0;
        end else begin
            rd_valid_out <= rd_accept;
            if (rd_accept) begin
                rd_data_out <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + DEPTH_LOG2'(1);
            end

            if (wr_accept) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end

            if (sample_seen && !wr_accept) begin
                overflow <= 1'b1;
            end

            case ({wr_accept, rd_accept})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase

            if (sample_seen) begin
                seen_cnt <= seen_next;
            end

            if ((state == CAPTURE) && (len_hit || stop_in)) begin
                state <= DONE;
            end
        end
    end

    // Sample storage; contents need no reset because the pointers and
    // count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    assign count_out    = count;
    assign empty_out    = (count == '0);
    assign full_out     = (count == FULL_COUNT);
    assign overflow_out = overflow;
    assign busy_out     = (state == CAPTURE);
    assign done_out     = (state == DONE);

endmodule

// File: tb/tb_vco_adc_capture.sv
// tb_vco_adc_capture
// ------------------
// Self-checking bench for vco_adc_capture. A behavioural model built on a
// queue tracks what the capture buffer should hold and report; directed
// scenarios cover bounded capture, readback, overflow, full-with-read,
// restart/stop collisions and mid-capture reset, followed by a randomized
// run compared against the model every cycle.
module tb_vco_adc_capture;

    localparam int DW    = 32;
    localparam int DL2   = 4;
    localparam int LW    = 10;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] sample_in;
    logic          sample_valid_in;
    logic          start_in;
    logic          stop_in;
    logic [LW-1:0] capture_len_in;
    logic          rd_en_in;
    logic [DW-1:0] rd_data_out;
    logic          rd_valid_out;
    logic [DL2:0]  count_out;
    logic          empty_out;
    logic          full_out;
    logic          overflow_out;
    logic          busy_out;
    logic          done_out;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [DW-1:0] m_q[$];
    bit            m_busy;
    bit            m_done;
    bit            m_ovf;
    int            m_len;
    int            m_seen;
    logic [DW-1:0] m_rd_data;
    bit            m_rd_valid;

    vco_adc_capture #(
        .DATA_WIDTH(DW),
        .DEPTH_LOG2(DL2),
        .LEN_WIDTH (LW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_in      (sample_in),
        .sample_valid_in(sample_valid_in),
        .start_in       (start_in),
        .stop_in        (stop_in),
        .capture_len_in (capture_len_in),
        .rd_en_in       (rd_en_in),
        .rd_data_out    (rd_data_out),
        .rd_valid_out   (rd_valid_out),
        .count_out      (count_out),
        .empty_out      (empty_out),
        .full_out       (full_out),
        .overflow_out   (overflow_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: applies one clock edge's worth of behaviour using the inputs
    // currently driven, from the buffer's point of view.
    task automatic model_update();
        bit rd;
        bit wr;
        int pre_size;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_done = 0; m_ovf = 0;
            m_len = 0; m_seen = 0;
            m_rd_data = '0; m_rd_valid = 0;
        end else if (start_in) begin
            m_q.delete();
            m_busy = 1; m_done = 0; m_ovf = 0;
            m_len = int'(capture_len_in); m_seen = 0;
            m_rd_valid = 0;
        end else begin
            pre_size = m_q.size();
            rd = rd_en_in && (pre_size > 0);
            wr = m_busy && sample_valid_in;
            m_rd_valid = rd;
            if (rd) m_rd_data = m_q.pop_front();
            if (wr) begin
                m_seen++;
                if (pre_size < DEPTH || rd) m_q.push_back(sample_in);
                else m_ovf = 1;
            end
            if (m_busy && ((wr && m_len != 0 && m_seen == m_len) || stop_in)) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model,
    // and return at the following negedge where outputs are stable.
    task automatic cycle(input bit r, input bit st, input bit sp, input bit v,
                         input logic [DW-1:0] d, input logic [LW-1:0] l, input bit rd);
        rst = r; start_in = st; stop_in = sp; sample_valid_in = v;
        sample_in = d; capture_len_in = l; rd_en_in = rd;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic push(input logic [DW-1:0] d);
        cycle(0, 0, 0, 1, d, '0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, '0, '0, 0);
        cycle(1, 0, 0, 0, '0, '0, 0);
        checks++;
        if ({count_out, empty_out, full_out, overflow_out, busy_out, done_out, rd_valid_out} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_flags: got count=%0d empty=%b full=%b ovf=%b busy=%b done=%b rv=%b, want 0 1 0 0 0 0 0",
                     count_out, empty_out, full_out, overflow_out, busy_out, done_out, rd_valid_out);
        end
        checks++;
        if (rd_data_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data_out);
        end
        idle_cycle();
    endtask

    task automatic test_bounded_capture();
        cycle(0, 1, 0, 0, '0, 10'd5, 0);
        for (int i = 0; i < 5; i++) begin
            push(32'h100 + i);
            if (i < 4) begin
                checks++;
                if (busy_out !== 1'b1 || done_out !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL bounded_busy[%0d]: got busy=%b done=%b want 1 0", i, busy_out, done_out);
                end
                idle_cycle();
                idle_cycle();
            end
        end
        checks++;
        if (done_out !== 1'b1 || busy_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bounded_done: got done=%b busy=%b want 1 0", done_out, busy_out);
        end
        push(32'h1FF);
        push(32'h1FE);
        checks++;
        if (count_out !== 5'd5 || overflow_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bounded_count: got count=%0d ovf=%b want 5 0", count_out, overflow_out);
        end
    endtask

    task automatic test_readback();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0, '0, '0, 1);
            checks++;
            if (rd_valid_out !== (i < 5)) begin
                failures++;
                $display("[TB] FAIL readback_valid[%0d]: got %b want %b", i, rd_valid_out, (i < 5));
            end
            if (i < 5) begin
                checks++;
                if (rd_data_out !== 32'h100 + i) begin
                    failures++;
                    $display("[TB] FAIL readback_data[%0d]: got %h want %h", i, rd_data_out, 32'h100 + i);
                end
            end
        end
        idle_cycle();
        checks++;
        if (empty_out !== 1'b1 || count_out !== 5'd0) begin
            failures++;
            $display("[TB] FAIL readback_empty: got empty=%b count=%0d want 1 0", empty_out, count_out);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] vals [20];
        cycle(0, 1, 0, 0, '0, 10'd0, 0);
        for (int i = 0; i < 20; i++) begin
            vals[i] = $urandom;
            push(vals[i]);
        end
        checks++;
        if (count_out !== 5'd16 || full_out !== 1'b1 || overflow_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_flags: got count=%0d full=%b ovf=%b want 16 1 1", count_out, full_out, overflow_out);
        end
        cycle(0, 0, 1, 0, '0, '0, 0);
        checks++;
        if (done_out !== 1'b1 || busy_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow_stop: got done=%b busy=%b want 1 0", done_out, busy_out);
        end
        for (int i = 0; i < 17; i++) begin
            cycle(0, 0, 0, 0, '0, '0, 1);
            checks++;
            if (rd_valid_out !== (i < 16) || (i < 16 && rd_data_out !== vals[i])) begin
                failures++;
                $display("[TB] FAIL overflow_read[%0d]: got rv=%b data=%h want rv=%b data=%h",
                         i, rd_valid_out, rd_data_out, (i < 16), (i < 16) ? vals[i] : rd_data_out);
            end
        end
    endtask

    task automatic test_full_rdwr();
        logic [DW-1:0] last;
        cycle(0, 1, 0, 0, '0, 10'd0, 0);
        for (int i = 0; i < 16; i++) push(32'h2000 + i);
        cycle(0, 0, 0, 1, 32'hAA, '0, 1);
        checks++;
        if (count_out !== 5'd16 || overflow_out !== 1'b0 || rd_data_out !== 32'h2000) begin
            failures++;
            $display("[TB] FAIL full_rdwr: got count=%0d ovf=%b data=%h want 16 0 00002000", count_out, overflow_out, rd_data_out);
        end
        cycle(0, 0, 1, 0, '0, '0, 0);
        last = '0;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 0, 0, '0, '0, 1);
            last = rd_data_out;
        end
        checks++;
        if (last !== 32'hAA) begin
            failures++;
            $display("[TB] FAIL full_rdwr_last: got %h want 000000aa", last);
        end
    endtask

    task automatic test_restart_collisions();
        cycle(0, 1, 0, 0, '0, 10'd0, 0);
        for (int i = 0; i < 20; i++) push(32'h3000 + i);
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, '0, '0, 1);
        checks++;
        if (count_out !== 5'd7 || overflow_out !== 1'b1 || busy_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_pre: got count=%0d ovf=%b busy=%b want 7 1 1", count_out, overflow_out, busy_out);
        end
        cycle(0, 1, 0, 1, 32'hDEAD, 10'd3, 1);
        checks++;
        if (count_out !== 5'd0 || overflow_out !== 1'b0 || busy_out !== 1'b1 || rd_valid_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL restart_clear: got count=%0d ovf=%b busy=%b rv=%b want 0 0 1 0",
                     count_out, overflow_out, busy_out, rd_valid_out);
        end
        push(32'h4001);
        push(32'h4002);
        push(32'h4003);
        checks++;
        if (done_out !== 1'b1 || count_out !== 5'd3) begin
            failures++;
            $display("[TB] FAIL restart_len: got done=%b count=%0d want 1 3", done_out, count_out);
        end
        cycle(0, 0, 0, 0, '0, '0, 1);
        checks++;
        if (rd_data_out !== 32'h4001) begin
            failures++;
            $display("[TB] FAIL start_sample_dropped: got %h want 00004001", rd_data_out);
        end
        cycle(0, 1, 0, 0, '0, 10'd0, 0);
        push(32'h5001);
        push(32'h5002);
        cycle(0, 0, 1, 1, 32'h5A5A, '0, 0);
        checks++;
        if (done_out !== 1'b1 || count_out !== 5'd3) begin
            failures++;
            $display("[TB] FAIL stop_collision: got done=%b count=%0d want 1 3", done_out, count_out);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, '0, '0, 1);
        checks++;
        if (rd_data_out !== 32'h5A5A) begin
            failures++;
            $display("[TB] FAIL stop_sample_kept: got %h want 00005a5a", rd_data_out);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 0, 0, '0, 10'd0, 0);
        for (int i = 0; i < 9; i++) push($urandom);
        checks++;
        if (count_out !== 5'd9 || busy_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_pre: got count=%0d busy=%b want 9 1", count_out, busy_out);
        end
        cycle(1, 0, 0, 1, 32'h77, '0, 1);
        checks++;
        if (count_out !== 5'd0 || empty_out !== 1'b1 || busy_out !== 1'b0 || done_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid: got count=%0d empty=%b busy=%b done=%b want 0 1 0 0",
                     count_out, empty_out, busy_out, done_out);
        end
        cycle(0, 0, 0, 0, '0, '0, 1);
        checks++;
        if (rd_valid_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_read: got rv=%b want 0", rd_valid_out);
        end
    endtask

    task automatic test_random();
        logic [DL2:0] exp_count;
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 99) < 55),
                  $urandom,
                  LW'($urandom_range(0, 24)),
                  ($urandom_range(0, 99) < 40));
            exp_count = (DL2 + 1)'(m_q.size());
            checks++;
            if ({count_out, empty_out, full_out, overflow_out, busy_out, done_out, rd_valid_out} !==
                {exp_count, (m_q.size() == 0), (m_q.size() == DEPTH), m_ovf, m_busy, m_done, m_rd_valid}) begin
                failures++;
                $display("[TB] FAIL random_status[%0d]: got count=%0d e=%b f=%b o=%b b=%b d=%b rv=%b want %0d %b %b %b %b %b %b",
                         n, count_out, empty_out, full_out, overflow_out, busy_out, done_out, rd_valid_out,
                         exp_count, (m_q.size() == 0), (m_q.size() == DEPTH), m_ovf, m_busy, m_done, m_rd_valid);
            end
            checks++;
            if (rd_data_out !== m_rd_data) begin
                failures++;
                $display("[TB] FAIL random_data[%0d]: got %h want %h", n, rd_data_out, m_rd_data);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; stop_in = 1'b0; sample_valid_in = 1'b0;
        sample_in = '0; capture_len_in = '0; rd_en_in = 1'b0;
        m_busy = 0; m_done = 0; m_ovf = 0; m_len = 0; m_seen = 0;
        m_rd_data = '0; m_rd_valid = 0;
        test_reset();
        test_bounded_capture();
        test_readback();
        test_overflow();
        test_full_rdwr();
        test_restart_collisions();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
